// File: rtl/seg_pkg.sv
// Shared definitions for the scanned seven-segment driver:
// slot phase enum, segment ROM, off pattern and nibble decoder.
package seg_pkg;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } slot_state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high patterns {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] SEG_ROM [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hexToSeg(input logic [3:0] nibble, input logic activeLow);
        logic [6:0] seg;
        seg = SEG_ROM[nibble];
        return activeLow ? ~seg : seg;
    endfunction

    function automatic logic [6:0] segOff(input logic activeLow);
        return activeLow ? ~SEG_OFF : SEG_OFF;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Load/data and scanned display signals of seg_scan_display; the driver
// sits on the slave side, whoever supplies the value on the master side.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    load_ack;
    logic                    frame_done;

    modport master (
        output load, data_in,
        input  seg_out, dig_en, load_ack, frame_done
    );

    modport slave (
        input  load, data_in,
        output seg_out, dig_en, load_ack, frame_done
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment decoder with selectable polarity.
module seg_hex_decode
    import seg_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hexToSeg(i_nibble, ACTIVE_LOW != 0);

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex display driver with tear-free frame-boundary commit.
// Define SEG_SCAN_BLANK_EN to suppress leading zeros (digit 0 always shown).
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_display_if.slave bus
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam logic AL   = (ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0]      CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST       = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_DARK       = segOff(AL);
    localparam logic [NUM_DIGITS-1:0] DIG_DARK       = AL ? '1 : '0;

    slot_state_t           r_state;
    slot_state_t           w_nextState;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_display;
    logic [DATA_W-1:0]     r_pending;
    logic                  r_pend;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;
    logic                  r_loadAck;
    logic                  r_frameDone;

    logic                  w_slotEnd;
    logic                  w_frameEnd;
    logic                  w_commit;
    logic [3:0]            w_nibble;
    logic [6:0]            w_decoded;
    logic                  w_leadBlank;
    logic [NUM_DIGITS-1:0] w_digOneHot;
    logic [6:0]            w_segNext;
    logic [NUM_DIGITS-1:0] w_digNext;

    assign w_slotEnd   = (r_cnt == CNT_LAST);
    assign w_frameEnd  = w_slotEnd && (r_idx == IDX_LAST);
    assign w_commit    = w_frameEnd && (r_pend || bus.load);
    assign w_nibble    = r_display[{r_idx, 2'b00} +: 4];
    assign w_digOneHot = NUM_DIGITS'(1) << r_idx;

`ifdef SEG_SCAN_BLANK_EN
    assign w_leadBlank = (r_idx != '0) && ((r_display >> {r_idx, 2'b00}) == '0);
`else
    assign w_leadBlank = 1'b0;
`endif

    seg_hex_decode #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_decode (
        .i_nibble(w_nibble),
        .o_seg   (w_decoded)
    );

    // Phase tracks the slot counter: BLANK for the first BLANK_CYCLES counts
    always_comb begin
        w_nextState = r_state;
        w_segNext   = SEG_DARK;
        w_digNext   = DIG_DARK;
        if (w_slotEnd) begin
            w_nextState = ST_BLANK;
        end else if (r_cnt == CNT_LAST_BLANK) begin
            w_nextState = ST_SHOW;
        end
        if (r_state == ST_SHOW) begin
            w_digNext = AL ? ~w_digOneHot : w_digOneHot;
            w_segNext = w_leadBlank ? SEG_DARK : w_decoded;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_BLANK;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_display   <= '0;
            r_pending   <= '0;
            r_pend      <= 1'b0;
            r_seg       <= SEG_DARK;
            r_dig       <= DIG_DARK;
            r_loadAck   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_slotEnd ? '0 : r_cnt + 1'b1;
            if (w_slotEnd) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            // A load landing on the boundary bypasses pending entirely
            if (w_frameEnd) begin
                if (bus.load) begin
                    r_display <= bus.data_in;
                end else if (r_pend) begin
                    r_display <= r_pending;
                end
                r_pend <= 1'b0;
            end else if (bus.load) begin
                r_pending <= bus.data_in;
                r_pend    <= 1'b1;
            end
            r_seg       <= w_segNext;
            r_dig       <= w_digNext;
            r_loadAck   <= w_commit;
            r_frameDone <= w_frameEnd;
        end
    end

    assign bus.seg_out    = r_seg;
    assign bus.dig_en     = r_dig;
    assign bus.load_ack   = r_loadAck;
    assign bus.frame_done = r_frameDone;

endmodule
